// File: rtl/phit_packer_float.sv
// phit_packer_float: assembles a stream of 64-bit doubles into phit-wide words.
// An early close via s_last emits a zero-padded phit together with a per-lane keep mask.
module phit_packer_float #(
  parameter int PHIT_SIZE = 512,
  parameter int DWIDTH    = 64,
  parameter int LANES     = PHIT_SIZE / DWIDTH,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DWIDTH-1:0]    s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PHIT_SIZE-1:0] m_data,
  output logic [LANES-1:0]     m_keep,
  output logic                 m_last,
  output logic [CNT_W-1:0]     phit_cnt
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  logic [LANES-1:0][DWIDTH-1:0] r_asm;
  logic [LANES-1:0]             r_keep;
  logic [IDX_W-1:0]             r_cnt;
  logic                         r_m_valid;
  logic [LANES-1:0][DWIDTH-1:0] r_m_data;
  logic [LANES-1:0]             r_m_keep;
  logic                         r_m_last;
  logic [CNT_W-1:0]             r_phit_cnt;

  logic                         w_in_fire;
  logic                         w_out_fire;
  logic                         w_close;
  logic [LANES-1:0][DWIDTH-1:0] w_next_data;
  logic [LANES-1:0]             w_next_keep;

  assign s_ready    = !r_m_valid || m_ready;
  assign w_in_fire  = s_valid && s_ready;
  assign w_out_fire = r_m_valid && m_ready;
  assign w_close    = (r_cnt == LAST_LANE) || s_last;

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_keep   = r_m_keep;
  assign m_last   = r_m_last;
  assign phit_cnt = r_phit_cnt;

  // Assembly contents with the incoming element merged at lane r_cnt; lanes above are zeroed.
  always_comb begin
    w_next_data = {(LANES * DWIDTH){1'b0}};
    w_next_keep = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (IDX_W'(i) < r_cnt) begin
        w_next_data[i] = r_asm[i];
        w_next_keep[i] = r_keep[i];
      end else if (IDX_W'(i) == r_cnt) begin
        w_next_data[i] = s_data;
        w_next_keep[i] = 1'b1;
      end else begin
        w_next_data[i] = {DWIDTH{1'b0}};
        w_next_keep[i] = 1'b0;
      end
    end
  end

  // Assembly register: accumulate lanes, clear on close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm  <= {(LANES * DWIDTH){1'b0}};
      r_keep <= {LANES{1'b0}};
      r_cnt  <= {IDX_W{1'b0}};
    end else if (w_in_fire) begin
      if (w_close) begin
        r_asm  <= {(LANES * DWIDTH){1'b0}};
        r_keep <= {LANES{1'b0}};
        r_cnt  <= {IDX_W{1'b0}};
      end else begin
        r_asm  <= w_next_data;
        r_keep <= w_next_keep;
        r_cnt  <= r_cnt + IDX_W'(1);
      end
    end
  end

  // Output register and accepted-phit counter; a close may reload while the old phit drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid  <= 1'b0;
      r_m_data   <= {(LANES * DWIDTH){1'b0}};
      r_m_keep   <= {LANES{1'b0}};
      r_m_last   <= 1'b0;
      r_phit_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_in_fire && w_close) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_next_data;
        r_m_keep  <= w_next_keep;
        r_m_last  <= s_last;
      end else if (w_out_fire) begin
        r_m_valid <= 1'b0;
      end
      if (w_out_fire) begin
        r_phit_cnt <= r_phit_cnt + CNT_W'(1);
      end
    end
  end

endmodule
